ifetch_stage: RTL
=================

Name: ifetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 32-bit DLX-style pipeline.
- Holds the PC and issues word requests to instruction memory over a variable-latency req/ack handshake.
- Resolves redirects from the decode stage, using the IFetch control signals produced by Control from the instruction in ID.
- Presents the fetched instruction and its OpCode/Function fields to decode and Control.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h5400_0000, bubble instruction placed in IF/ID on flush/empty

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; one clock, synchronous, active-low
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  fetch address; stable while imem_req high and not acked
imem_ack  in  1  request done; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
id_stall  in  1  hazard stall from decode; IF/ID holds
id_jump_type  in  2  Control JumpType for ID instr: 00 seq, 01 cond branch, 10 jump PC-relative, 11 jump register
id_branch_cond  in  1  Control BranchCond: 0 = BEQZ, 1 = BNEZ
id_cond_zero  in  1  condition operand (selected by CondSrc upstream) equals zero
id_imm  in  32  sign-extended offset of ID instr
id_reg_target  in  32  register operand for JumpType 11
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  IF/ID instruction
if_id_pc_plus4  out  32  address of IF/ID instr + 4
op_code  out  6  if_id_instr[31:26], to Control
function  out  6  if_id_instr[5:0], to Control

Behaviour:
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, state=FETCH, skid empty.
  - imem_req=0 during the reset cycle(s).
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_plus4=0.
  - Applies mid-transaction: an outstanding request is abandoned and a late ack is ignored.
  - First cycle after release: imem_req=1, imem_addr=RESET_PC.
- Redirect (combinational):
  - Qualified only when if_id_valid=1 and id_stall=0.
  - taken = (type 01 and (id_cond_zero XOR id_branch_cond)) or type 10 or type 11.
  - Target: types 01/10 use if_id_pc_plus4 + id_imm; type 11 uses id_reg_target. Bits [1:0] are forced to 00.
  - Arithmetic is mod 2^32; sequential pc+4 wraps FFFF_FFFC -> 0000_0000.
  - No delay slot: on a taken redirect, IF/ID becomes a bubble at the next edge.
- State FETCH (imem_req=1, imem_addr=pc):
  - ack, no stall, no redirect: IF/ID <= {1, rdata, pc+4}; pc += 4; stay in FETCH (back-to-back request next cycle).
  - ack, stall: skid <= {rdata, pc+4}; pc += 4; go to HELD; IF/ID holds.
  - ack, redirect: rdata dropped; pc = target; IF/ID bubble; stay in FETCH.
  - no ack, redirect: pc = target; IF/ID bubble; go to DISCARD (imem_addr keeps the old address via a latched fetch address).
  - no ack, no redirect: IF/ID bubble if not stalled, else hold.
- State HELD (imem_req=0):
  - stall: hold everything.
  - stall=0, no redirect: IF/ID <= skid; go to FETCH.
  - stall=0, redirect: skid discarded; IF/ID bubble; pc = target; go to FETCH.
- State DISCARD (imem_req=1, old address):
  - Wait for ack; data dropped; go to FETCH with the target pc.
  - IF/ID stays bubble.
  - No redirect is possible here because IF/ID is invalid.
- Output timing:
  - op_code and function are pure slices of if_id_instr, so Control sees them in the same cycle.
  - All other outputs are registered except imem_req and imem_addr, which decode from state and registers.
  - Steady-state throughput with a 0-wait ack is one instruction per cycle.

Test Plan:
- Reset then ack every cycle, id_jump_type=00: imem_addr sequence 0,4,8,C; IF/ID valid from cycle 2 with if_id_pc_plus4=4,8,C; op_code/function match rdata[31:26]/[5:0].
- Ack delayed 3 cycles: imem_addr held stable at 0x10 with imem_req=1 across all wait cycles; IF/ID shows 3 bubbles (valid=0, NOP_INSTR).
- id_stall=1 for 4 cycles while ack arrives: state HELD with imem_req=0 and IF/ID unchanged; on release the skid instr appears in IF/ID next cycle and fetch resumes at the following address.
- BEQZ (type 01, branch_cond=0, cond_zero=1, pc_plus4=0x20, imm=0x40) with ack same cycle: next imem_addr=0x60, IF/ID bubble. Same instruction with cond_zero=0: no redirect.
- JR (type 11, reg_target=0x1003) while a request to 0x24 is outstanding: the 0x24 ack is dropped via DISCARD, next request is 0x1000, and no 0x24 instruction ever appears in IF/ID.
- rst_n low during an outstanding request with ack arriving in the reset cycle: data ignored; after release imem_addr=RESET_PC and if_id_valid=0.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage and IF/ID register.
// PC, imem req/ack, redirect resolution, one-entry skid.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr         fetch request and word address
//   imem_ack/rdata        request done, fetched word
//   id_stall              decode hazard stall (IF/ID holds)
//   id_jump_type          00 seq, 01 cond, 10 jump rel, 11 jump reg
//   id_branch_cond        0 BEQZ, 1 BNEZ
//   id_cond_zero          condition operand is zero
//   id_imm                sign-extended offset of ID instr
//   id_reg_target         register target for type 11
//   if_id_valid/instr     IF/ID contents
//   if_id_pc_plus4        address of IF/ID instr + 4
//   op_code, function_o   instr[31:26], instr[5:0]
//   (function_o: "function" is a reserved word)
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h5400_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic [1:0]  id_jump_type,
  input  logic        id_branch_cond,
  input  logic        id_cond_zero,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_reg_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [5:0]  op_code,
  output logic [5:0]  function_o
);

  typedef enum logic [1:0] {
    FETCH,
    HELD,
    DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] sk_pc4_q, sk_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic        taken;
  logic        redir;
  logic [31:0] tgt_raw;
  logic [31:0] target;
  logic [31:0] pc_inc;

  always_comb begin
    unique case (id_jump_type)
      2'b01:        taken = id_cond_zero ^ id_branch_cond;
      2'b10, 2'b11: taken = 1'b1;
      default:      taken = 1'b0;
    endcase
  end

  // Only a real, non-stalled ID instruction may redirect.
  assign redir   = valid_q & ~id_stall & taken;
  assign tgt_raw = (id_jump_type == 2'b11) ? id_reg_target
                                           : pc4_q + id_imm;
  assign target  = {tgt_raw[31:2], 2'b00};
  assign pc_inc  = pc_q + 32'd4;

  // Gated by rst_n so no request leaks out while reset is held.
  assign imem_req  = rst_n & (state_q != HELD);
  // DISCARD keeps presenting the abandoned address until its ack.
  assign imem_addr = (state_q == DISCARD) ? fa_q : pc_q;

  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign op_code        = instr_q[31:26];
  assign function_o     = instr_q[5:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fa_d       = fa_q;
    sk_instr_d = sk_instr_q;
    sk_pc4_d   = sk_pc4_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          if (redir) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = target;
          end else if (id_stall) begin
            sk_instr_d = imem_rdata;
            sk_pc4_d   = pc_inc;
            pc_d       = pc_inc;
            state_d    = HELD;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            pc_d    = pc_inc;
          end
        end else if (redir) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          fa_d    = pc_q;
          pc_d    = target;
          state_d = DISCARD;
        end else if (!id_stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      HELD: begin
        if (!id_stall) begin
          state_d = FETCH;
          if (redir) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = target;
          end else begin
            valid_d = 1'b1;
            instr_d = sk_instr_q;
            pc4_d   = sk_pc4_q;
          end
        end
      end
      DISCARD: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      fa_q       <= RESET_PC;
      sk_instr_q <= NOP_INSTR;
      sk_pc4_q   <= 32'd0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc4_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fa_q       <= fa_d;
      sk_instr_q <= sk_instr_d;
      sk_pc4_q   <= sk_pc4_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
    end
  end

endmodule
